mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15: maximum wait cycles for mem_ready before trap (range 1..255).
REQ-002 SHALL have parameter CNT_W, default 8: width of wait counter; WAIT_MAX SHALL be < 2^CNT_W.
REQ-003 SHALL have ports, one per line:
 clk  in  1  clock, all state on rising edge.
 reset  in  1  asynchronous, active-low reset.
 opcode  in  6  instruction[31:26] from external IR, valid from DECODE onward.
 funct  in  6  instruction[5:0] from external IR.
 zero  in  1  rs==rt compare result, sampled in EXEC.
 mem_ready  in  1  memory handshake completion.
 mem_req  out  1  memory request (IM in FETCH, DM in MEM).
 PCWrite  out  1  PC load strobe.
 IRWrite  out  1  IR load strobe.
 MemWrite  out  1  DM write strobe.
 RegWrite  out  1  GRF write strobe.
 REGorMEM  out  1  1 = write-back data from DM.
 NPCOp  out  3  000 PC+4, 001 branch, 010 j-target, 011 register.
 ZeroEXT  out  1  1 = zero-extend imm16.
 A1op  out  2  01 = shift source from rt.
 A3op  out  2  00 rd, 01 rt, 10 $31.
 REGop  out  2  00 ALU/DM, 01 lui, 10 PC+8 link.
 ALU_Bop  out  2  00 reg, 01 imm, 10 shamt.
 ALUOp  out  4  team ALU op codes (ADD, SUB, OR, AND, SLL, SRL, SRA, SLT).
 state  out  3  current FSM state, debug.
 illegal  out  1  sticky trap flag.

Function
REQ-004 SHALL decode addu, subu, sll, srl, sra, slt, jr, jalr (opcode 000000), ori, lw, sw, beq, lui, j, jal with standard MIPS encodings and the datapath select values of the single-cycle controller.
REQ-005 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; 6 and 7 SHALL go to TRAP.
REQ-006 FETCH: mem_req=1; on mem_ready: IRWrite=1, PCWrite=1, NPCOp=000 for that cycle, next DECODE; else stay.
REQ-007 DECODE: undefined opcode/funct -> TRAP; j: PCWrite=1, NPCOp=010 -> FETCH; jal: additionally RegWrite=1, A3op=10, REGop=10; jr: PCWrite=1, NPCOp=011 -> FETCH; jalr: as jr plus RegWrite=1, A3op=00, REGop=10; all others -> EXEC.
REQ-008 EXEC: ALU selects driven per instruction; beq: PCWrite=zero, NPCOp=001 -> FETCH; lw/sw -> MEM; R-type ALU, ori, lui -> WB.
REQ-009 MEM: mem_req=1, MemWrite=1 only for sw; on mem_ready sw -> FETCH, lw -> WB; else stay.
REQ-010 WB: RegWrite=1 single cycle, REGorMEM=1 for lw only, A3op=01 for ori/lui/lw -> FETCH.
REQ-011 Select outputs SHALL be held stable for the instruction from DECODE through WB; strobes SHALL be asserted only in the states listed.
REQ-012 Wait counter SHALL clear on entry to FETCH/MEM, increment each cycle mem_req=1 and mem_ready=0; reaching WAIT_MAX without mem_ready -> TRAP; mem_ready on the WAIT_MAX-th cycle SHALL complete normally.
REQ-013 TRAP: illegal=1, all strobes 0, mem_req=0; exit only by reset.
REQ-014 Latency with zero memory wait: j/jal/jr/jalr 2 cycles, beq 3, R-type/ori/lui/sw 4, lw 5; each wait cycle adds 1.

Reset
REQ-015 While reset=0: state=FETCH, counter=0, illegal=0, all strobes and mem_req forced 0, selects 0; asynchronous, mid-instruction abort without any write.
REQ-016 First rising edge after reset release SHALL be in FETCH with mem_req=1.

Verification
REQ-017 addu (funct 100001), mem_ready tied 1 -> states 0,1,2,4,0; RegWrite=1 only in WB, ALUOp=ADD.
REQ-018 lw with DM mem_ready delayed 3 cycles -> MEM held 4 cycles, WB with REGorMEM=1, total 8 cycles.
REQ-019 beq zero=0 then zero=1 -> PCWrite=0 then PCWrite=1 with NPCOp=001 in EXEC, 3 cycles each.
REQ-020 opcode 111111 in DECODE -> TRAP, illegal=1, no strobes until reset; reset -> FETCH, illegal=0.
REQ-021 mem_ready held 0 in FETCH, WAIT_MAX=15 -> TRAP after 15 cycles; ready on 15th cycle -> DECODE.
REQ-022 reset asserted mid-MEM of sw -> MemWrite drops immediately, state=0.

Source files
------------

// File: rtl/mc_controller.sv
// Multi-cycle MIPS-subset control FSM: FETCH/DECODE/EXEC/MEM/WB with a bounded
// memory-wait counter and a sticky TRAP state left only through reset.
module mc_controller #(
   parameter int unsigned WAIT_MAX = 15,
   parameter int unsigned CNT_W    = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       PCWrite,
   output logic       IRWrite,
   output logic       MemWrite,
   output logic       RegWrite,
   output logic       REGorMEM,
   output logic [2:0] NPCOp,
   output logic       ZeroEXT,
   output logic [1:0] A1op,
   output logic [1:0] A3op,
   output logic [1:0] REGop,
   output logic [1:0] ALU_Bop,
   output logic [3:0] ALUOp,
   output logic [2:0] state,
   output logic       illegal
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_e;

   typedef enum logic [3:0] {
      C_NONE, C_RALU, C_JR, C_JALR, C_ORI, C_LW, C_SW, C_BEQ, C_LUI, C_J, C_JAL
   } cls_e;

   typedef enum logic [3:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_OR  = 4'd2,
      ALU_AND = 4'd3,
      ALU_SLL = 4'd4,
      ALU_SRL = 4'd5,
      ALU_SRA = 4'd6,
      ALU_SLT = 4'd7
   } alu_e;

   typedef struct packed {
      logic [2:0] npc_op;
      logic       zero_ext;
      logic [1:0] a1_op;
      logic [1:0] a3_op;
      logic [1:0] reg_op;
      logic [1:0] alu_b_op;
      logic [3:0] alu_op;
      logic       reg_or_mem;
   } sel_t;

   state_e           state_q, state_d;
   cls_e             cls_q, cls_d, dec_cls;
   sel_t             sel_q, sel_d, dec_sel, sel_o;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             illegal_q, illegal_d;
   logic             wait_last;

   assign wait_last = (cnt_q == CNT_W'(WAIT_MAX - 1));

   // Instruction decode; C_NONE marks an undefined opcode/funct.
   always_comb begin
      dec_cls = C_NONE;
      dec_sel = '0;
      case (opcode)
         6'b000000: begin
            case (funct)
               6'b100001: begin dec_cls = C_RALU; dec_sel.alu_op = ALU_ADD; end
               6'b100011: begin dec_cls = C_RALU; dec_sel.alu_op = ALU_SUB; end
               6'b101010: begin dec_cls = C_RALU; dec_sel.alu_op = ALU_SLT; end
               6'b000000: begin
                  dec_cls          = C_RALU;
                  dec_sel.a1_op    = 2'b01;
                  dec_sel.alu_b_op = 2'b10;
                  dec_sel.alu_op   = ALU_SLL;
               end
               6'b000010: begin
                  dec_cls          = C_RALU;
                  dec_sel.a1_op    = 2'b01;
                  dec_sel.alu_b_op = 2'b10;
                  dec_sel.alu_op   = ALU_SRL;
               end
               6'b000011: begin
                  dec_cls          = C_RALU;
                  dec_sel.a1_op    = 2'b01;
                  dec_sel.alu_b_op = 2'b10;
                  dec_sel.alu_op   = ALU_SRA;
               end
               6'b001000: begin dec_cls = C_JR; dec_sel.npc_op = 3'b011; end
               6'b001001: begin
                  dec_cls        = C_JALR;
                  dec_sel.npc_op = 3'b011;
                  dec_sel.a3_op  = 2'b00;
                  dec_sel.reg_op = 2'b10;
               end
               default: dec_cls = C_NONE;
            endcase
         end
         6'b001101: begin
            dec_cls          = C_ORI;
            dec_sel.zero_ext = 1'b1;
            dec_sel.a3_op    = 2'b01;
            dec_sel.alu_b_op = 2'b01;
            dec_sel.alu_op   = ALU_OR;
         end
         6'b100011: begin
            dec_cls            = C_LW;
            dec_sel.a3_op      = 2'b01;
            dec_sel.alu_b_op   = 2'b01;
            dec_sel.alu_op     = ALU_ADD;
            dec_sel.reg_or_mem = 1'b1;
         end
         6'b101011: begin
            dec_cls          = C_SW;
            dec_sel.alu_b_op = 2'b01;
            dec_sel.alu_op   = ALU_ADD;
         end
         6'b000100: begin
            dec_cls        = C_BEQ;
            dec_sel.npc_op = 3'b001;
            dec_sel.alu_op = ALU_SUB;
         end
         6'b001111: begin
            dec_cls          = C_LUI;
            dec_sel.a3_op    = 2'b01;
            dec_sel.reg_op   = 2'b01;
            dec_sel.alu_b_op = 2'b01;
         end
         6'b000010: begin dec_cls = C_J; dec_sel.npc_op = 3'b010; end
         6'b000011: begin
            dec_cls        = C_JAL;
            dec_sel.npc_op = 3'b010;
            dec_sel.a3_op  = 2'b10;
            dec_sel.reg_op = 2'b10;
         end
         default: dec_cls = C_NONE;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      cls_d     = cls_q;
      sel_d     = sel_q;
      cnt_d     = cnt_q;
      case (state_q)
         S_FETCH: begin
            if (mem_ready)      state_d = S_DECODE;
            else if (wait_last) state_d = S_TRAP;
            else                cnt_d   = cnt_q + CNT_W'(1);
         end
         S_DECODE: begin
            cls_d = dec_cls;
            sel_d = dec_sel;
            case (dec_cls)
               C_NONE:                   state_d = S_TRAP;
               C_J, C_JAL, C_JR, C_JALR: state_d = S_FETCH;
               default:                  state_d = S_EXEC;
            endcase
         end
         S_EXEC: begin
            case (cls_q)
               C_BEQ:      state_d = S_FETCH;
               C_LW, C_SW: state_d = S_MEM;
               default:    state_d = S_WB;
            endcase
         end
         S_MEM: begin
            if (mem_ready)      state_d = (cls_q == C_SW) ? S_FETCH : S_WB;
            else if (wait_last) state_d = S_TRAP;
            else                cnt_d   = cnt_q + CNT_W'(1);
         end
         S_WB:    state_d = S_FETCH;
         default: state_d = S_TRAP;
      endcase
      // Any state change clears the counter, so FETCH and MEM always start at zero.
      if (state_d != state_q) cnt_d = '0;
      illegal_d = illegal_q | (state_d == S_TRAP);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_FETCH;
         cls_q     <= C_NONE;
         sel_q     <= '0;
         cnt_q     <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cls_q     <= cls_d;
         sel_q     <= sel_d;
         cnt_q     <= cnt_d;
         illegal_q <= illegal_d;
      end
   end

   // Strobes follow the live state; reset gates them so an abort never writes.
   always_comb begin
      sel_o    = '0;
      mem_req  = 1'b0;
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
      if (reset) begin
         case (state_q)
            S_FETCH: begin
               mem_req = 1'b1;
               IRWrite = mem_ready;
               PCWrite = mem_ready;
            end
            S_DECODE: begin
               sel_o    = dec_sel;
               PCWrite  = (dec_cls == C_J) || (dec_cls == C_JAL) ||
                          (dec_cls == C_JR) || (dec_cls == C_JALR);
               RegWrite = (dec_cls == C_JAL) || (dec_cls == C_JALR);
            end
            S_EXEC: begin
               sel_o   = sel_q;
               PCWrite = (cls_q == C_BEQ) && zero;
            end
            S_MEM: begin
               sel_o    = sel_q;
               mem_req  = 1'b1;
               MemWrite = (cls_q == C_SW);
            end
            S_WB: begin
               sel_o    = sel_q;
               RegWrite = 1'b1;
            end
            default: sel_o = '0;
         endcase
      end
   end

   assign NPCOp    = sel_o.npc_op;
   assign ZeroEXT  = sel_o.zero_ext;
   assign A1op     = sel_o.a1_op;
   assign A3op     = sel_o.a3_op;
   assign REGop    = sel_o.reg_op;
   assign ALU_Bop  = sel_o.alu_b_op;
   assign ALUOp    = sel_o.alu_op;
   assign REGorMEM = sel_o.reg_or_mem;
   assign state    = state_q;
   assign illegal  = illegal_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: state traces, strobes and selects per cycle.
module tb_mc_controller;

   logic       clk;
   logic       reset;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       mem_req, PCWrite, IRWrite, MemWrite, RegWrite, REGorMEM, ZeroEXT, illegal;
   logic [2:0] NPCOp, state;
   logic [1:0] A1op, A3op, REGop, ALU_Bop;
   logic [3:0] ALUOp;

   int errors = 0;
   int checks = 0;

   // {state, mem_req, PCWrite, IRWrite, MemWrite, RegWrite}
   logic [7:0]  strb;
   // {NPCOp, ZeroEXT, A1op, A3op, REGop, ALU_Bop, ALUOp, REGorMEM}
   logic [16:0] sel;
   assign strb = {state, mem_req, PCWrite, IRWrite, MemWrite, RegWrite};
   assign sel  = {NPCOp, ZeroEXT, A1op, A3op, REGop, ALU_Bop, ALUOp, REGorMEM};

   mc_controller #(.WAIT_MAX(15), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .PCWrite(PCWrite), .IRWrite(IRWrite),
      .MemWrite(MemWrite), .RegWrite(RegWrite), .REGorMEM(REGorMEM), .NPCOp(NPCOp),
      .ZeroEXT(ZeroEXT), .A1op(A1op), .A3op(A3op), .REGop(REGop), .ALU_Bop(ALU_Bop),
      .ALUOp(ALUOp), .state(state), .illegal(illegal)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic release_reset;
      mem_ready = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1; mem_ready = 1'b1; opcode = 6'h00; funct = 6'h21; zero = 1'b0;
      #1;
      reset = 1'b0;
      #2;
      checks++; if (strb !== {3'd0, 5'b00000}) begin errors++; $display("FAIL reset_async: got %b want %b", strb, {3'd0, 5'b00000}); end
      checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b want 0", illegal); end
      tick; tick;
      checks++; if ({strb, sel} !== 25'd0) begin errors++; $display("FAIL reset_held: got %b want 0", {strb, sel}); end
      release_reset;
      checks++; if (strb !== {3'd0, 5'b10000}) begin errors++; $display("FAIL reset_release: got %b want %b", strb, {3'd0, 5'b10000}); end
   endtask

   task automatic test_addu;
      opcode = 6'b000000; funct = 6'b100001; mem_ready = 1'b1;
      #1;
      checks++; if ({strb, NPCOp} !== {3'd0, 5'b11100, 3'b000}) begin errors++; $display("FAIL addu_fetch: got %b want %b", {strb, NPCOp}, {3'd0, 5'b11100, 3'b000}); end
      tick;
      checks++; if (strb !== {3'd1, 5'b00000}) begin errors++; $display("FAIL addu_decode: got %b want %b", strb, {3'd1, 5'b00000}); end
      tick;
      checks++; if ({strb, ALUOp} !== {3'd2, 5'b00000, 4'd0}) begin errors++; $display("FAIL addu_exec: got %b want %b", {strb, ALUOp}, {3'd2, 5'b00000, 4'd0}); end
      tick;
      checks++; if ({strb, sel} !== {3'd4, 5'b00001, 17'd0}) begin errors++; $display("FAIL addu_wb: got %b want %b", {strb, sel}, {3'd4, 5'b00001, 17'd0}); end
      tick;
      mem_ready = 1'b0; #1;
      checks++; if (strb !== {3'd0, 5'b10000}) begin errors++; $display("FAIL addu_done: got %b want %b", strb, {3'd0, 5'b10000}); end
   endtask

   task automatic test_lw_wait;
      logic [16:0] lw_sel;
      lw_sel = {3'b000, 1'b0, 2'b00, 2'b01, 2'b00, 2'b01, 4'd0, 1'b1};
      opcode = 6'b100011; funct = 6'h00; mem_ready = 1'b1;
      #1; tick;
      checks++; if ({strb, sel} !== {3'd1, 5'b00000, lw_sel}) begin errors++; $display("FAIL lw_decode: got %b want %b", {strb, sel}, {3'd1, 5'b00000, lw_sel}); end
      tick;
      checks++; if ({strb, sel} !== {3'd2, 5'b00000, lw_sel}) begin errors++; $display("FAIL lw_exec: got %b want %b", {strb, sel}, {3'd2, 5'b00000, lw_sel}); end
      tick;
      for (int i = 0; i < 4; i++) begin
         mem_ready = (i == 3);
         #1;
         checks++; if ({strb, sel} !== {3'd3, 5'b10000, lw_sel}) begin errors++; $display("FAIL lw_mem%0d: got %b want %b", i, {strb, sel}, {3'd3, 5'b10000, lw_sel}); end
         tick;
      end
      mem_ready = 1'b0;
      checks++; if ({strb, sel} !== {3'd4, 5'b00001, lw_sel}) begin errors++; $display("FAIL lw_wb: got %b want %b", {strb, sel}, {3'd4, 5'b00001, lw_sel}); end
      tick;
      checks++; if (strb !== {3'd0, 5'b10000}) begin errors++; $display("FAIL lw_done: got %b want %b", strb, {3'd0, 5'b10000}); end
   endtask

   task automatic test_beq;
      logic [16:0] beq_sel;
      beq_sel = {3'b001, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 4'd1, 1'b0};
      opcode = 6'b000100; funct = 6'h00;
      for (int z = 0; z < 2; z++) begin
         zero = (z == 1); mem_ready = 1'b1;
         #1; tick; tick;
         checks++; if ({strb, sel} !== {3'd2, 1'b0, (z == 1), 3'b000, beq_sel}) begin errors++; $display("FAIL beq_exec_z%0d: got %b want %b", z, {strb, sel}, {3'd2, 1'b0, (z == 1), 3'b000, beq_sel}); end
         tick;
         mem_ready = 1'b0; #1;
         checks++; if (strb !== {3'd0, 5'b10000}) begin errors++; $display("FAIL beq_done_z%0d: got %b want %b", z, strb, {3'd0, 5'b10000}); end
      end
      zero = 1'b0;
   endtask

   task automatic test_jumps;
      logic [5:0]  ops [4];
      logic [5:0]  fns [4];
      logic [16:0] sels [4];
      logic        rw [4];
      ops  = '{6'b000010, 6'b000011, 6'b000000, 6'b000000};
      fns  = '{6'h00, 6'h00, 6'b001000, 6'b001001};
      sels = '{{3'b010, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 4'd0, 1'b0},
               {3'b010, 1'b0, 2'b00, 2'b10, 2'b10, 2'b00, 4'd0, 1'b0},
               {3'b011, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 4'd0, 1'b0},
               {3'b011, 1'b0, 2'b00, 2'b00, 2'b10, 2'b00, 4'd0, 1'b0}};
      rw   = '{1'b0, 1'b1, 1'b0, 1'b1};
      for (int k = 0; k < 4; k++) begin
         opcode = ops[k]; funct = fns[k]; mem_ready = 1'b1;
         #1; tick;
         checks++; if ({strb, sel} !== {3'd1, 4'b0100, rw[k], sels[k]}) begin errors++; $display("FAIL jump%0d_decode: got %b want %b", k, {strb, sel}, {3'd1, 4'b0100, rw[k], sels[k]}); end
         tick;
         mem_ready = 1'b0; #1;
         checks++; if (strb !== {3'd0, 5'b10000}) begin errors++; $display("FAIL jump%0d_done: got %b want %b", k, strb, {3'd0, 5'b10000}); end
      end
   endtask

   task automatic test_alu_selects;
      logic [16:0] ori_sel, sll_sel;
      ori_sel = {3'b000, 1'b1, 2'b00, 2'b01, 2'b00, 2'b01, 4'd2, 1'b0};
      sll_sel = {3'b000, 1'b0, 2'b01, 2'b00, 2'b00, 2'b10, 4'd4, 1'b0};
      opcode = 6'b001101; funct = 6'h3f; mem_ready = 1'b1;
      #1; tick; tick;
      checks++; if ({strb, sel} !== {3'd2, 5'b00000, ori_sel}) begin errors++; $display("FAIL ori_exec: got %b want %b", {strb, sel}, {3'd2, 5'b00000, ori_sel}); end
      tick;
      checks++; if ({strb, sel} !== {3'd4, 5'b00001, ori_sel}) begin errors++; $display("FAIL ori_wb: got %b want %b", {strb, sel}, {3'd4, 5'b00001, ori_sel}); end
      tick;
      opcode = 6'b000000; funct = 6'b000000;
      #1; tick; tick;
      checks++; if ({strb, sel} !== {3'd2, 5'b00000, sll_sel}) begin errors++; $display("FAIL sll_exec: got %b want %b", {strb, sel}, {3'd2, 5'b00000, sll_sel}); end
      tick; tick;
      mem_ready = 1'b0; #1;
      checks++; if (strb !== {3'd0, 5'b10000}) begin errors++; $display("FAIL sll_done: got %b want %b", strb, {3'd0, 5'b10000}); end
   endtask

   task automatic test_illegal;
      opcode = 6'b111111; funct = 6'h00; mem_ready = 1'b1;
      #1; tick;
      checks++; if (strb !== {3'd1, 5'b00000}) begin errors++; $display("FAIL ill_decode: got %b want %b", strb, {3'd1, 5'b00000}); end
      tick; tick; tick;
      checks++; if ({strb, illegal} !== {3'd5, 5'b00000, 1'b1}) begin errors++; $display("FAIL ill_trap: got %b want %b", {strb, illegal}, {3'd5, 5'b00000, 1'b1}); end
      reset = 1'b0; #2;
      checks++; if ({state, illegal} !== 4'b0000) begin errors++; $display("FAIL ill_reset: got %b want 0000", {state, illegal}); end
      release_reset;
   endtask

   task automatic test_fetch_timeout;
      opcode = 6'b000010; funct = 6'h00; mem_ready = 1'b0;
      for (int i = 0; i < 15; i++) begin
         #1;
         checks++; if (strb !== {3'd0, 5'b10000}) begin errors++; $display("FAIL timeout_wait%0d: got %b want %b", i, strb, {3'd0, 5'b10000}); end
         tick;
      end
      checks++; if ({strb, illegal} !== {3'd5, 5'b00000, 1'b1}) begin errors++; $display("FAIL timeout_trap: got %b want %b", {strb, illegal}, {3'd5, 5'b00000, 1'b1}); end
      reset = 1'b0; #2;
      release_reset;
   endtask

   task automatic test_fetch_ready_last;
      opcode = 6'b000010; funct = 6'h00;
      for (int i = 0; i < 15; i++) begin
         mem_ready = (i == 14);
         #1;
         checks++; if (strb !== {3'd0, 1'b1, (i == 14), (i == 14), 2'b00}) begin errors++; $display("FAIL ready15_cyc%0d: got %b want %b", i, strb, {3'd0, 1'b1, (i == 14), (i == 14), 2'b00}); end
         tick;
      end
      checks++; if ({strb, illegal} !== {3'd1, 5'b01000, 1'b0}) begin errors++; $display("FAIL ready15_decode: got %b want %b", {strb, illegal}, {3'd1, 5'b01000, 1'b0}); end
      tick;
      mem_ready = 1'b0; #1;
   endtask

   task automatic test_reset_mid_sw;
      opcode = 6'b101011; funct = 6'h00; mem_ready = 1'b1;
      #1; tick; tick; tick;
      mem_ready = 1'b0; #1;
      checks++; if (strb !== {3'd3, 5'b10010}) begin errors++; $display("FAIL sw_mem: got %b want %b", strb, {3'd3, 5'b10010}); end
      reset = 1'b0; #1;
      checks++; if ({strb, sel} !== 25'd0) begin errors++; $display("FAIL sw_abort: got %b want 0", {strb, sel}); end
      release_reset;
      checks++; if (strb !== {3'd0, 5'b10000}) begin errors++; $display("FAIL sw_restart: got %b want %b", strb, {3'd0, 5'b10000}); end
   endtask

   initial begin
      test_reset;
      test_addu;
      test_lw_wait;
      test_beq;
      test_jumps;
      test_alu_selects;
      test_illegal;
      test_fetch_timeout;
      test_fetch_ready_last;
      test_reset_mid_sw;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
